text_cell_sequencer: RTL and testbench
======================================

Name: text_cell_sequencer

Overview:
- Stage between the VGA timing generator and the glyph renderer.
- Converts raw pixel coordinates into character-cell coordinates using incremental counters, replacing the per-pixel divide-by-5 and divide-by-9.
- Holds a writable 32-character line buffer and delivers a registered, pixel-aligned glyph index and in-cell offsets to the renderer.
- A host loads text through a byte-stream valid/ready port.

Parameters:
- N, 32: line buffer depth in characters; power of two; column index is col[log2(N)-1:0].
- CELL_W, 5: cell width in pixels.
- CELL_H, 9: cell height in pixels; the last row (yy==CELL_H-1) is the inter-line gap.

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- hpos  input  10  horizontal pixel position from timing generator
- vpos  input  10  vertical pixel position from timing generator
- display_on  input  1  active-video flag from timing generator
- wr_valid  input  1  host byte valid
- wr_data  input  8  host byte (ASCII)
- wr_ready  output  1  byte accepted this cycle when wr_valid && wr_ready
- active  output  1  display_on delayed one cycle
- col  output  7  cell column (hpos/CELL_W)
- row  output  6  cell row (vpos/CELL_H)
- xx  output  3  pixel within cell, 0..CELL_W-1
- yy  output  4  line within cell, 0..CELL_H-1
- glyph_idx  output  7  buffer[col mod N] - 32, range 0..95
- cursor_on  output  1  cell under the write pointer is in its visible blink phase

Behaviour:
- Reset: all outputs 0 except wr_ready=1; buffer cells = 0x20 (space); write pointer wp=0.
- Latency: every cell output is one cycle after the hpos/vpos/display_on sample it describes.
- hpos advances by exactly 1 per clk within a line.
- Horizontal counters, each cycle:
  - hpos==0: xx<=0, col<=0.
  - else xx==CELL_W-1: xx<=0, col<=col+1.
  - else xx<=xx+1.
  - col saturates at 127.
- Vertical counters, updated only on cycles with hpos==0:
  - vpos==0: yy<=0, row<=0.
  - else yy==CELL_H-1: yy<=0, row<=row+1.
  - else yy<=yy+1.
  - row saturates at 63.
  - Between updates yy/row hold for the whole line.
- Equivalence requirement: for every hpos<640, vpos<480, col==hpos/5, xx==hpos%5, row==vpos/9, yy==vpos%9.
- glyph_idx is registered from buffer[next_col[4:0]] - 32, so it stays aligned with col.
- Write handshake:
  - wr_ready = !display_on (combinational). No writes during active video, so no tearing.
  - On accept, 0x0D sets wp<=0 and writes nothing.
  - Other bytes below 0x20 or above 0x7F are stored as 0x3F '?'.
  - Printable bytes go to buffer[wp], then wp<=wp+1, wrapping N-1 -> 0.
- wr_valid held while wr_ready=0: the byte stays pending. Host must hold wr_data stable until accepted.
- Reset asserted mid-line or mid-write: the byte is not written; next cycle is the reset state. Counters resync at the next hpos==0 / vpos==0 after release.
- Reset and wr_valid in the same cycle: reset wins.
- display_on falling while wr_valid is high: accept on the first cycle wr_ready=1.

Optional Feature:
- CURSOR_EN defined:
  - 5-bit frame counter increments on each cycle with hpos==0 && vpos==0; reset to 0.
  - cursor_on = active && (col[4:0]==wp) && frame_cnt[4], registered alongside glyph_idx.
  - Renderer inverts that cell.
- CURSOR_EN undefined: cursor_on tied to 0; no frame counter logic.

Test Plan:
- Reset, then sweep hpos 0..639 with vpos=0 -> col/xx match hpos/5, hpos%5 one cycle later; e.g. hpos=13 gives col=2, xx=3; hpos=639 gives col=127, xx=4.
- Sweep vpos 0..479 with hpos cycling 0..799 -> row/yy correct; vpos=17 gives row=1, yy=8; vpos=479 gives row=53, yy=2.
- In blanking, write "AB" -> buffer[0]=0x41, buffer[1]=0x42, wp=2. During display at col=1, glyph_idx=0x22.
- Assert wr_valid during display_on=1 -> wr_ready=0, no write. After display_on falls -> accepted in that cycle.
- Write 33 bytes '0'..'P' -> buffer[0]=0x50 after wrap. Then write 0x0D -> wp=0. Then write 0x07 -> buffer[0]=0x3F.
- With CURSOR_EN and wp=3: frame_cnt 0..15 -> cursor_on=0. Frames 16..31 at col=3 while active -> cursor_on=1, 0 at other columns. Without CURSOR_EN -> cursor_on stays 0.

Source files
------------

// File: rtl/text_cell_sequencer.sv
// text_cell_sequencer: incremental pixel-to-cell counters, writable line buffer and glyph index.
// Optional blinking cursor enabled by defining CURSOR_EN.
module text_cell_sequencer #(
  parameter int N = 32,
  parameter int CELL_W = 5,
  parameter int CELL_H = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       active,
  output logic [6:0] col,
  output logic [5:0] row,
  output logic [2:0] xx,
  output logic [3:0] yy,
  output logic [6:0] glyph_idx,
  output logic       cursor_on
);
  localparam int AW = $clog2(N);
  logic [7:0] buf_q [N];
  logic [7:0] buf_d [N];
  logic [AW-1:0] wp_q, wp_d;
  logic [2:0] xx_q, xx_d;
  logic [6:0] col_q, col_d;
  logic [3:0] yy_q, yy_d;
  logic [5:0] row_q, row_d;
  logic [6:0] glyph_q, glyph_d;
  logic active_q;
  logic hz, xw, yw;
  logic [7:0] wbyte;
  always_comb begin
    hz = hpos == 10'd0;
    xw = xx_q == 3'(CELL_W - 1);
    yw = yy_q == 4'(CELL_H - 1);
    xx_d = (hz || xw) ? 3'd0 : xx_q + 3'd1;
    col_d = hz ? 7'd0 : (xw && col_q != 7'd127) ? col_q + 7'd1 : col_q;
    yy_d = !hz ? yy_q : (vpos == 10'd0 || yw) ? 4'd0 : yy_q + 4'd1;
    row_d = !hz ? row_q : (vpos == 10'd0) ? 6'd0 : (yw && row_q != 6'd63) ? row_q + 6'd1 : row_q;
    // look up with the column being computed now so glyph_idx lands with col
    glyph_d = 7'(buf_q[col_d[AW-1:0]] - 8'h20);
    wr_ready = !display_on;
    wbyte = (wr_data < 8'h20 || wr_data > 8'h7f) ? 8'h3f : wr_data;
    buf_d = buf_q;
    wp_d = wp_q;
    if (wr_valid && wr_ready) begin
      wp_d = (wr_data == 8'h0d) ? '0 : wp_q + 1'b1;
      if (wr_data != 8'h0d) buf_d[wp_q] = wbyte;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      xx_q <= '0;
      col_q <= '0;
      yy_q <= '0;
      row_q <= '0;
      glyph_q <= '0;
      active_q <= 1'b0;
      wp_q <= '0;
      buf_q <= '{default: 8'h20};
    end else begin
      xx_q <= xx_d;
      col_q <= col_d;
      yy_q <= yy_d;
      row_q <= row_d;
      glyph_q <= glyph_d;
      active_q <= display_on;
      wp_q <= wp_d;
      buf_q <= buf_d;
    end
  end
`ifdef CURSOR_EN
  logic [4:0] fc_q, fc_d;
  logic cursor_q, cursor_d;
  always_comb begin
    fc_d = (hz && vpos == 10'd0) ? fc_q + 5'd1 : fc_q;
    cursor_d = display_on && col_d[AW-1:0] == wp_q && fc_q[4];
  end
  always_ff @(posedge clk) begin
    fc_q <= reset ? 5'd0 : fc_d;
    cursor_q <= reset ? 1'b0 : cursor_d;
  end
  assign cursor_on = cursor_q;
`else
  assign cursor_on = 1'b0;
`endif
  assign active = active_q;
  assign col = col_q;
  assign row = row_q;
  assign xx = xx_q;
  assign yy = yy_q;
  assign glyph_idx = glyph_q;
endmodule

// File: tb/tb_text_cell_sequencer.sv
// tb_text_cell_sequencer: scoreboard bench; expected cells come from a divide/modulo reference model.
module tb_text_cell_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic display_on = 1'b0;
  logic wr_valid = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic [7:0] wr_data = '0;
  logic wr_ready, active, cursor_on;
  logic [6:0] col, glyph_idx;
  logic [5:0] row;
  logic [2:0] xx;
  logic [3:0] yy;
  typedef struct packed {
    logic       act;
    logic [6:0] col;
    logic [5:0] row;
    logic [2:0] xx;
    logic [3:0] yy;
    logic [6:0] g;
    logic       cur;
  } cell_t;
  cell_t q[$];
  cell_t e, o;
  logic [7:0] mem [32];
  logic [4:0] wp_m, fc_m;
  logic rdy_s;
  int vec = 0;
  int err = 0;

  text_cell_sequencer dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .active(active),
    .col(col), .row(row), .xx(xx), .yy(yy), .glyph_idx(glyph_idx), .cursor_on(cursor_on)
  );

  always #5 clk = ~clk;
  assign o = {active, col, row, xx, yy, glyph_idx, cursor_on};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input int h, input int v, input logic d, input logic wv,
                       input logic [7:0] wd, input logic chk);
    cell_t x;
    int c;
    @(negedge clk);
    reset = 1'b0; hpos = 10'(h); vpos = 10'(v); display_on = d; wr_valid = wv; wr_data = wd;
    c = (h / 5 > 127) ? 127 : h / 5;
    x.act = d; x.col = 7'(c); x.row = 6'(v / 9); x.xx = 3'(h % 5); x.yy = 4'(v % 9);
    x.g = 7'(mem[c % 32] - 8'h20);
`ifdef CURSOR_EN
    x.cur = d && 5'(c % 32) == wp_m && fc_m[4];
`else
    x.cur = 1'b0;
`endif
    if (chk) q.push_back(x);
    if (h == 0 && v == 0) fc_m = fc_m + 5'd1;
    if (wv && !d) begin
      if (wd == 8'h0d) wp_m = '0;
      else begin
        mem[wp_m] = (wd < 8'h20 || wd > 8'h7f) ? 8'h3f : wd;
        wp_m = wp_m + 5'd1;
      end
    end
    #1 rdy_s = wr_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; hpos = 10'd37; vpos = 10'd22; display_on = 1'b0; wr_valid = 1'b1; wr_data = 8'h5a;
    @(posedge clk); #1;
    vec++; if (o !== '0) begin err++; $display("FAIL reset_outputs got %h want 0", o); end
    vec++; if (wr_ready !== 1'b1) begin err++; $display("FAIL reset_ready got %b want 1", wr_ready); end
    @(negedge clk); display_on = 1'b1;
    @(posedge clk); #1;
    vec++; if (o !== '0) begin err++; $display("FAIL reset_hold got %h want 0", o); end
    vec++; if (wr_ready !== 1'b0) begin err++; $display("FAIL reset_ready_disp got %b want 0", wr_ready); end
    foreach (mem[i]) mem[i] = 8'h20;
    wp_m = '0; fc_m = '0;
  endtask

  task automatic test_hsweep;
    for (int h = 0; h < 800; h++) begin
      drive(h, 0, 1'b1, 1'b0, 8'h00, 1'b1);
      e = q.pop_front(); vec++;
      if (o !== e) begin err++; $display("FAIL hsweep h=%0d got %h want %h", h, o, e); end
      if (h == 13 || h == 639) begin
        vec++;
        if (col !== ((h == 13) ? 7'd2 : 7'd127) || xx !== ((h == 13) ? 3'd3 : 3'd4)) begin
          err++; $display("FAIL hsweep_point h=%0d got col=%0d xx=%0d", h, col, xx);
        end
      end
    end
  endtask

  task automatic test_vsweep;
    for (int v = 0; v < 480; v++)
      for (int h = 0; h < 4; h++) begin
        drive(h, v, 1'b0, 1'b0, 8'h00, 1'b1);
        e = q.pop_front(); vec++;
        if (o !== e) begin err++; $display("FAIL vsweep v=%0d h=%0d got %h want %h", v, h, o, e); end
        if (h == 1 && (v == 17 || v == 479)) begin
          vec++;
          if (row !== ((v == 17) ? 6'd1 : 6'd53) || yy !== ((v == 17) ? 4'd8 : 4'd2)) begin
            err++; $display("FAIL vsweep_point v=%0d got row=%0d yy=%0d", v, row, yy);
          end
        end
      end
  endtask

  task automatic test_write_ab;
    drive(1, 1, 1'b0, 1'b1, 8'h41, 1'b0);
    drive(2, 1, 1'b0, 1'b1, 8'h42, 1'b0);
    for (int h = 0; h < 25; h++) begin
      drive(h, 0, 1'b1, 1'b0, 8'h00, 1'b1);
      e = q.pop_front(); vec++;
      if (o !== e) begin err++; $display("FAIL write_ab h=%0d got %h want %h", h, o, e); end
      if (h == 7) begin
        vec++;
        if (glyph_idx !== 7'h22) begin err++; $display("FAIL write_ab_col1 got %h want 22", glyph_idx); end
      end
    end
  endtask

  task automatic test_hold;
    for (int i = 0; i < 4; i++) begin
      drive(3, 3, 1'b1, 1'b1, 8'h43, 1'b0);
      vec++; if (rdy_s !== 1'b0) begin err++; $display("FAIL hold_ready got %b want 0", rdy_s); end
    end
    drive(3, 3, 1'b0, 1'b1, 8'h43, 1'b0);
    vec++; if (rdy_s !== 1'b1) begin err++; $display("FAIL hold_release got %b want 1", rdy_s); end
    for (int h = 0; h < 25; h++) begin
      drive(h, 0, 1'b1, 1'b0, 8'h00, 1'b1);
      e = q.pop_front(); vec++;
      if (o !== e) begin err++; $display("FAIL hold h=%0d got %h want %h", h, o, e); end
      if (h == 12) begin
        vec++;
        if (glyph_idx !== 7'h23) begin err++; $display("FAIL hold_col2 got %h want 23", glyph_idx); end
      end
    end
  endtask

  task automatic test_wrap;
    drive(1, 1, 1'b0, 1'b1, 8'h0d, 1'b0);
    for (int i = 0; i < 33; i++) drive(1, 1, 1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
    for (int h = 0; h < 5; h++) begin
      drive(h, 0, 1'b1, 1'b0, 8'h00, 1'b1);
      e = q.pop_front(); vec++;
      if (o !== e) begin err++; $display("FAIL wrap h=%0d got %h want %h", h, o, e); end
    end
    vec++; if (glyph_idx !== 7'h30) begin err++; $display("FAIL wrap_col0 got %h want 30", glyph_idx); end
    drive(1, 1, 1'b0, 1'b1, 8'h0d, 1'b0);
    drive(1, 1, 1'b0, 1'b1, 8'h07, 1'b0);
    drive(1, 1, 1'b0, 1'b1, 8'h80, 1'b0);
    drive(1, 1, 1'b0, 1'b1, 8'h7f, 1'b0);
    for (int h = 0; h < 160; h++) begin
      drive(h, 0, 1'b1, 1'b0, 8'h00, 1'b1);
      e = q.pop_front(); vec++;
      if (o !== e) begin err++; $display("FAIL wrap_ctl h=%0d got %h want %h", h, o, e); end
      if (h == 0 || h == 10) begin
        vec++;
        if (glyph_idx !== ((h == 0) ? 7'h1f : 7'h5f)) begin
          err++; $display("FAIL wrap_ctl_point h=%0d got %h", h, glyph_idx);
        end
      end
    end
  endtask

  task automatic test_cursor;
    drive(1, 1, 1'b0, 1'b1, 8'h0d, 1'b0);
    drive(1, 1, 1'b0, 1'b1, 8'h78, 1'b0);
    drive(1, 1, 1'b0, 1'b1, 8'h79, 1'b0);
    drive(1, 1, 1'b0, 1'b1, 8'h7a, 1'b0);
    for (int f = 0; f < 32; f++)
      for (int h = 0; h < 25; h++) begin
        drive(h, 0, h != 0, 1'b0, 8'h00, 1'b1);
        e = q.pop_front(); vec++;
        if (o !== e) begin err++; $display("FAIL cursor f=%0d h=%0d got %h want %h", f, h, o, e); end
      end
  endtask

  initial begin
    test_reset;
    test_hsweep;
    test_vsweep;
    test_write_ab;
    test_hold;
    test_wrap;
    test_cursor;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
